// File: rtl/con_ff_param.sv
// con_ff_param: registered branch-condition flop with valid/ack handshake.
// Optional saturating statistics counters built when CON_STATS_EN is defined.
`timescale 1ns/1ps
module con_ff_param #(
  parameter int DATA_W   = 32,
  parameter int IR_W     = 32,
  parameter int COND_LSB = 19,
  parameter int COND_W   = 2,
  parameter int STAT_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [IR_W-1:0]   ir,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              con_in,
  input  logic              con_ack,
  output logic              con_out,
  output logic              con_valid
`ifdef CON_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] eval_count,
  output logic [STAT_W-1:0] taken_count
`endif
);

  generate
    if ((COND_W != 2 && COND_W != 3) ||
        (COND_LSB + COND_W > IR_W)) begin : g_cfg_err
      $error("con_ff_param: illegal COND_W/COND_LSB/IR_W");
    end
  endgenerate

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state;
  logic [2:0] code;
  logic       z;
  logic       s;
  logic       eval;
  logic       unused_ir;

  // Only the condition field of ir is decoded.
  assign unused_ir = ^ir;

  // Field is zero-extended so a 2-bit field always lands in the legacy set.
  always_comb begin
    code = '0;
    code[COND_W-1:0] = ir[COND_LSB +: COND_W];
  end

  // Flag generation and condition decode.
  always_comb begin
    z    = (bus_in == '0);
    s    = bus_in[DATA_W-1];
    eval = 1'b0;
    unique case (code)
      3'b000: eval = z;
      3'b001: eval = !z;
      3'b010: eval = !s;
      3'b011: eval = s;
      3'b100: eval = 1'b1;
      3'b101: eval = 1'b0;
      3'b110: eval = !s && !z;
      3'b111: eval = s || z;
    endcase
  end

  // Capture/consume FSM; a new capture always wins over an ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      con_out   <= 1'b0;
      con_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (con_in) begin
            con_out   <= eval;
            con_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (con_in) begin
            con_out   <= eval;
            con_valid <= 1'b1;
          end else if (con_ack) begin
            con_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef CON_STATS_EN
  // Saturating capture/taken counters; clear beats a same-cycle capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eval_count  <= '0;
      taken_count <= '0;
    end else if (stat_clr) begin
      eval_count  <= '0;
      taken_count <= '0;
    end else if (con_in) begin
      if (eval_count != '1)
        eval_count <= eval_count + 1'b1;
      if (eval && taken_count != '1)
        taken_count <= taken_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_con_ff_param.sv
// Bench for con_ff_param: legacy (COND_W=2) and extended (COND_W=3) instances.
// Per-cycle model compare plus directed literal checks.
`timescale 1ns/1ps
module tb_con_ff_param;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] ir;
  logic [31:0] bus_in;
  logic        con_in;
  logic        con_ack;
  logic        out_l, val_l, out_e, val_e;
`ifdef CON_STATS_EN
  logic        stat_clr;
  logic [15:0] ev_l, tk_l;
  logic [1:0]  ev_e, tk_e;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  always #5 clock = ~clock;

  con_ff_param u_leg (
    .clock(clock), .reset_n(reset_n), .ir(ir), .bus_in(bus_in),
    .con_in(con_in), .con_ack(con_ack),
    .con_out(out_l), .con_valid(val_l)
`ifdef CON_STATS_EN
    , .stat_clr(stat_clr), .eval_count(ev_l), .taken_count(tk_l)
`endif
  );

  con_ff_param #(.COND_W(3), .STAT_W(2)) u_ext (
    .clock(clock), .reset_n(reset_n), .ir(ir), .bus_in(bus_in),
    .con_in(con_in), .con_ack(con_ack),
    .con_out(out_e), .con_valid(val_e)
`ifdef CON_STATS_EN
    , .stat_clr(stat_clr), .eval_count(ev_e), .taken_count(tk_e)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Condition meaning as signed arithmetic on the bus value.
  function automatic bit model_eval(input int code, input logic [31:0] v);
    int sv;
    sv = $signed(v);
    case (code)
      0: return sv == 0;
      1: return sv != 0;
      2: return sv >= 0;
      3: return sv < 0;
      4: return 1'b1;
      5: return 1'b0;
      6: return sv > 0;
      default: return sv <= 0;
    endcase
  endfunction

  bit m_out[2];
  bit m_val[2];
  int m_ev[2];
  int m_tk[2];
  int m_max[2] = '{65535, 3};

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_out[i] <= 0; m_val[i] <= 0; m_ev[i] <= 0; m_tk[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int  c;
        bit  r;
        c = (i == 0) ? int'(ir[20:19]) : int'(ir[21:19]);
        r = model_eval(c, bus_in);
        if (con_in) begin
          m_out[i] <= r;
          m_val[i] <= 1;
        end else if (m_val[i] && con_ack) begin
          m_val[i] <= 0;
        end
`ifdef CON_STATS_EN
        if (stat_clr) begin
          m_ev[i] <= 0; m_tk[i] <= 0;
        end else if (con_in) begin
          if (m_ev[i] < m_max[i]) m_ev[i] <= m_ev[i] + 1;
          if (r && m_tk[i] < m_max[i]) m_tk[i] <= m_tk[i] + 1;
        end
`endif
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (check_en) begin
      check("mdl_leg_out", out_l, m_out[0]);
      check("mdl_leg_valid", val_l, m_val[0]);
      check("mdl_ext_out", out_e, m_out[1]);
      check("mdl_ext_valid", val_e, m_val[1]);
`ifdef CON_STATS_EN
      check("mdl_leg_ev", ev_l, m_ev[0]);
      check("mdl_leg_tk", tk_l, m_tk[0]);
      check("mdl_ext_ev", ev_e, m_ev[1]);
      check("mdl_ext_tk", tk_e, m_tk[1]);
`endif
    end
  end

  task automatic cyc(input logic [2:0] code, input logic [31:0] v,
                     input logic ci, input logic ack, input logic clr);
    @(negedge clock);
    ir      = 32'h5A47_0C3C & ~(32'h7 << 19);
    ir      = ir | (32'(code) << 19);
    bus_in  = v;
    con_in  = ci;
    con_ack = ack;
`ifdef CON_STATS_EN
    stat_clr = clr;
`else
    if (clr) $display("stat_clr ignored without stats");
`endif
    @(posedge clock);
    #3;
  endtask

  bit          exp_tab[12] = '{1,0,0, 0,1,1, 1,1,0, 0,0,1};
  logic [31:0] vals[3]     = '{32'd0, 32'd5, 32'h8000_0000};
  logic [2:0]  x_code[8]   = '{3'd6, 3'd6, 3'd7, 3'd4, 3'd5, 3'd7, 3'd6, 3'd7};
  logic [31:0] x_bus[8]    = '{32'd0, 32'd7, 32'd0, 32'h1234, 32'd0,
                               32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
  bit          x_exp[8]    = '{0,1,1,1,0,0,0,1};

  initial begin
    reset_n = 0; ir = 0; bus_in = 0; con_in = 0; con_ack = 0;
`ifdef CON_STATS_EN
    stat_clr = 0;
`endif
    repeat (2) @(negedge clock);
    check("rst_leg_out", out_l, 0);
    check("rst_leg_valid", val_l, 0);
    check("rst_ext_valid", val_e, 0);
    reset_n = 1;
    check_en = 1;

    // legacy table, back-to-back captures
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < 3; b++) begin
        cyc(3'(c), vals[b], 1, 0, 0);
        check($sformatf("leg_c%0d_b%0d", c, b), out_l, exp_tab[c*3+b]);
        check($sformatf("leg_e_c%0d_b%0d", c, b), out_e, exp_tab[c*3+b]);
        check("b2b_valid", val_l, 1);
      end

    // extended set on the 3-bit instance
    for (int k = 0; k < 8; k++) begin
      cyc(x_code[k], x_bus[k], 1, 0, 0);
      check($sformatf("ext_%0d", k), out_e, x_exp[k]);
    end

    // handshake
    cyc(0, 0, 0, 1, 0);
    check("ack_to_idle", val_l, 0);
    cyc(0, 0, 1, 0, 0);
    check("hs_e1_valid", val_l, 1);
    check("hs_e1_out", out_l, 1);
    cyc(0, 5, 0, 0, 0);
    check("hs_e2_valid", val_l, 1);
    cyc(0, 5, 0, 1, 0);
    check("hs_e3_valid", val_l, 0);
    check("hs_e3_out", out_l, 1);
    cyc(0, 5, 0, 1, 0);
    check("idle_ack_valid", val_e, 0);
    check("idle_ack_out", out_e, 1);

    // capture and ack together, new result 0
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    check("sim_out", out_l, 0);
    check("sim_valid", val_l, 1);

    // async reset in HOLD
    cyc(0, 0, 1, 0, 0);
    check("pre_rst_out", out_e, 1);
    @(negedge clock);
    reset_n = 0; con_in = 0; con_ack = 0;
    #1;
    check("arst_out", out_l, 0);
    check("arst_valid", val_l, 0);
    check("arst_e_out", out_e, 0);
    @(negedge clock);
    reset_n = 1;
    cyc(0, 0, 0, 1, 0);
    check("post_rst_valid", val_l, 0);
    check("post_rst_out", out_l, 0);

`ifdef CON_STATS_EN
    check("st_rst_ev", ev_e, 0);
    repeat (5) cyc(4, 0, 1, 0, 0);
    check("st_ext_ev_sat", ev_e, 3);
    check("st_ext_tk_sat", tk_e, 3);
    check("st_leg_ev", ev_l, 5);
    check("st_leg_tk", tk_l, 5);
    cyc(4, 0, 1, 0, 1);
    check("st_clr_ev", ev_e, 0);
    check("st_clr_tk", tk_l, 0);
    cyc(5, 0, 1, 0, 0);
    check("st_nt_ev", ev_e, 1);
    check("st_nt_tk", tk_e, 0);
    check("st_nt_leg_tk", tk_l, 0);
    cyc(0, 0, 0, 0, 1);
    check("st_clr2_ev", ev_l, 0);
`endif

    cyc(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
